string_eval: RTL and testbench

STRING_EVAL -- requirements
Module: string_eval

---
 rtl/string_eval_if.sv | 25 ++
 rtl/string_eval.sv | 136 +++++++++++++
 tb/tb_string_eval.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/string_eval_if.sv
// Character-stream bus for the expression evaluator: the producer drives
// characters with a valid strobe, and the evaluator returns its value and status.
interface string_eval_if;
    logic [7:0]  in;
    logic        in_valid;
    logic [15:0] result;
    logic        legal;
    logic        err;

    modport master (
        output in,
        output in_valid,
        input  result,
        input  legal,
        input  err
    );

    modport slave (
        input  in,
        input  in_valid,
        output result,
        output legal,
        output err
    );
endinterface

// File: rtl/string_eval.sv
// Streaming evaluator for single-digit integer expressions using +, - and *.
// Multiplication binds tighter than add/subtract; all arithmetic wraps at 16 bits.
module string_eval (
    input  logic          clk,
    input  logic          clr,
    string_eval_if.slave  bus
);
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_STAR  = 8'h2A;
    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_NINE  = 8'h39;

    typedef enum logic [1:0] {
        START       = 2'd0,
        AFTER_DIGIT = 2'd1,
        AFTER_OP    = 2'd2,
        ERROR       = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [15:0] sum_r, sum_s;
    logic [15:0] term_r, term_s;
    logic        neg_r, neg_s;
    logic [7:0]  last_op_r, last_op_s;
    logic [15:0] result_r, result_s;
    logic        legal_r, err_r;

    logic        is_digit_s;
    logic        is_op_s;
    logic [15:0] digit_s;

    function automatic logic [15:0] apply_sign(input logic neg, input logic [15:0] val);
        apply_sign = neg ? (16'd0 - val) : val;
    endfunction

    // Character classification
    always_comb begin
        is_digit_s = (bus.in >= CH_ZERO) && (bus.in <= CH_NINE);
        is_op_s    = (bus.in == CH_PLUS) || (bus.in == CH_MINUS) || (bus.in == CH_STAR);
        digit_s    = {8'd0, bus.in - CH_ZERO};
    end

    // Next-state and datapath update for one accepted character
    always_comb begin
        state_s   = state_r;
        sum_s     = sum_r;
        term_s    = term_r;
        neg_s     = neg_r;
        last_op_s = last_op_r;
        result_s  = result_r;
        if (bus.in_valid) begin
            case (state_r)
                START: begin
                    if (is_digit_s) begin
                        term_s   = digit_s;
                        neg_s    = 1'b0;
                        sum_s    = 16'd0;
                        result_s = digit_s;
                        state_s  = AFTER_DIGIT;
                    end else begin
                        result_s = 16'd0;
                        state_s  = ERROR;
                    end
                end
                AFTER_DIGIT: begin
                    if (is_op_s) begin
                        // '*' keeps extending the current term; '+'/'-' commit it to the sum
                        if (bus.in == CH_STAR) begin
                            last_op_s = CH_STAR;
                        end else begin
                            sum_s     = sum_r + apply_sign(neg_r, term_r);
                            neg_s     = (bus.in == CH_MINUS);
                            last_op_s = bus.in;
                        end
                        state_s = AFTER_OP;
                    end else begin
                        result_s = 16'd0;
                        state_s  = ERROR;
                    end
                end
                AFTER_OP: begin
                    if (is_digit_s) begin
                        if (last_op_r == CH_STAR) begin
                            term_s = term_r * digit_s;
                        end else begin
                            term_s = digit_s;
                        end
                        result_s = sum_r + apply_sign(neg_r, term_s);
                        state_s  = AFTER_DIGIT;
                    end else begin
                        result_s = 16'd0;
                        state_s  = ERROR;
                    end
                end
                ERROR: begin
                    result_s = 16'd0;
                    state_s  = ERROR;
                end
                default: begin
                    result_s = 16'd0;
                    state_s  = ERROR;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r   <= START;
            sum_r     <= 16'd0;
            term_r    <= 16'd0;
            neg_r     <= 1'b0;
            last_op_r <= CH_PLUS;
            result_r  <= 16'd0;
            legal_r   <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            sum_r     <= sum_s;
            term_r    <= term_s;
            neg_r     <= neg_s;
            last_op_r <= last_op_s;
            result_r  <= result_s;
            legal_r   <= (state_s == AFTER_DIGIT);
            err_r     <= (state_s == ERROR);
        end
    end

    assign bus.result = result_r;
    assign bus.legal  = legal_r;
    assign bus.err    = err_r;
endmodule

// File: tb/tb_string_eval.sv
// Directed self-checking bench for string_eval: one task per scenario,
// expected values computed by hand from the expression semantics.
module tb_string_eval;
    logic clk;
    logic clr;
    int   checks;
    int   errors;

    string_eval_if bus();

    string_eval dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send(input logic [7:0] c);
        @(negedge clk);
        bus.in       = c;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        #2;
        clr = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        bus.in = 8'h35;
        bus.in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.result !== 16'd0 || bus.legal !== 1'b0 || bus.err !== 1'b0) begin
            $display("FAIL reset: got result=%h legal=%b err=%b expected 0000/0/0", bus.result, bus.legal, bus.err);
            errors++;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_precedence();
        pulse_clr();
        send("1"); send("+"); send("2");
        checks++;
        if (bus.result !== 16'd3) begin
            $display("FAIL prec_partial: got %h expected 0003", bus.result);
            errors++;
        end
        send("*"); send("3");
        checks++;
        if (bus.result !== 16'd7 || bus.legal !== 1'b1 || bus.err !== 1'b0) begin
            $display("FAIL precedence: got result=%h legal=%b err=%b expected 0007/1/0", bus.result, bus.legal, bus.err);
            errors++;
        end
    endtask

    task automatic test_subtraction();
        pulse_clr();
        send("9"); send("-"); send("3"); send("-"); send("4");
        checks++;
        if (bus.result !== 16'd2 || bus.legal !== 1'b1) begin
            $display("FAIL left_assoc_sub: got result=%h legal=%b expected 0002/1", bus.result, bus.legal);
            errors++;
        end
        pulse_clr();
        send("0"); send("-"); send("9"); send("*"); send("9");
        checks++;
        if (bus.result !== 16'hFFAF || bus.legal !== 1'b1) begin
            $display("FAIL neg_product: got result=%h legal=%b expected FFAF/1", bus.result, bus.legal);
            errors++;
        end
    endtask

    task automatic test_wrap();
        pulse_clr();
        send("9");
        for (int i = 0; i < 4; i++) begin
            send("*");
            send("9");
        end
        checks++;
        if (bus.result !== 16'hE6A9 || bus.legal !== 1'b1) begin
            $display("FAIL wrap: got result=%h legal=%b expected E6A9/1", bus.result, bus.legal);
            errors++;
        end
    endtask

    task automatic test_errors();
        pulse_clr();
        send("+");
        checks++;
        if (bus.err !== 1'b1 || bus.result !== 16'd0 || bus.legal !== 1'b0) begin
            $display("FAIL err_op_first: got err=%b result=%h legal=%b expected 1/0000/0", bus.err, bus.result, bus.legal);
            errors++;
        end
        pulse_clr();
        send("1");
        checks++;
        if (bus.err !== 1'b0 || bus.result !== 16'd1 || bus.legal !== 1'b1) begin
            $display("FAIL err_first_digit: got err=%b result=%h legal=%b expected 0/0001/1", bus.err, bus.result, bus.legal);
            errors++;
        end
        send("2");
        checks++;
        if (bus.err !== 1'b1 || bus.result !== 16'd0 || bus.legal !== 1'b0) begin
            $display("FAIL err_two_digits: got err=%b result=%h legal=%b expected 1/0000/0", bus.err, bus.result, bus.legal);
            errors++;
        end
        pulse_clr();
        send("1"); send("a");
        checks++;
        if (bus.err !== 1'b1 || bus.result !== 16'd0) begin
            $display("FAIL err_illegal_char: got err=%b result=%h expected 1/0000", bus.err, bus.result);
            errors++;
        end
        send("+"); send("3");
        checks++;
        if (bus.err !== 1'b1 || bus.result !== 16'd0 || bus.legal !== 1'b0) begin
            $display("FAIL err_sticky: got err=%b result=%h legal=%b expected 1/0000/0", bus.err, bus.result, bus.legal);
            errors++;
        end
        pulse_clr();
        send("8");
        checks++;
        if (bus.err !== 1'b0 || bus.result !== 16'd8 || bus.legal !== 1'b1) begin
            $display("FAIL err_recover: got err=%b result=%h legal=%b expected 0/0008/1", bus.err, bus.result, bus.legal);
            errors++;
        end
    endtask

    task automatic test_gaps();
        pulse_clr();
        send("5"); send("*");
        checks++;
        if (bus.legal !== 1'b0 || bus.result !== 16'd5 || bus.err !== 1'b0) begin
            $display("FAIL incomplete: got legal=%b result=%h err=%b expected 0/0005/0", bus.legal, bus.result, bus.err);
            errors++;
        end
        @(negedge clk);
        bus.in = "7";
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.legal !== 1'b0 || bus.result !== 16'd5 || bus.err !== 1'b0) begin
            $display("FAIL gap_hold: got legal=%b result=%h err=%b expected 0/0005/0", bus.legal, bus.result, bus.err);
            errors++;
        end
        send("2");
        checks++;
        if (bus.legal !== 1'b1 || bus.result !== 16'd10) begin
            $display("FAIL gap_resume: got legal=%b result=%h expected 1/000a", bus.legal, bus.result);
            errors++;
        end
    endtask

    task automatic test_async_clear();
        pulse_clr();
        send("4"); send("+");
        checks++;
        if (bus.result !== 16'd4 || bus.legal !== 1'b0) begin
            $display("FAIL pre_clr: got result=%h legal=%b expected 0004/0", bus.result, bus.legal);
            errors++;
        end
        @(negedge clk);
        #2;
        clr = 1'b1;
        #1;
        checks++;
        if (bus.result !== 16'd0 || bus.legal !== 1'b0 || bus.err !== 1'b0) begin
            $display("FAIL async_clr: got result=%h legal=%b err=%b expected 0000/0/0", bus.result, bus.legal, bus.err);
            errors++;
        end
        clr = 1'b0;
        send("3");
        checks++;
        if (bus.result !== 16'd3 || bus.legal !== 1'b1 || bus.err !== 1'b0) begin
            $display("FAIL after_clr: got result=%h legal=%b err=%b expected 0003/1/0", bus.result, bus.legal, bus.err);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [0:6];
        seq[0] = "2"; seq[1] = "*"; seq[2] = "3"; seq[3] = "-";
        seq[4] = "4"; seq[5] = "*"; seq[6] = "5";
        pulse_clr();
        @(negedge clk);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.in = seq[i];
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        checks++;
        // 2*3 - 4*5 = -14
        if (bus.result !== 16'hFFF2 || bus.legal !== 1'b1 || bus.err !== 1'b0) begin
            $display("FAIL back_to_back: got result=%h legal=%b err=%b expected FFF2/1/0", bus.result, bus.legal, bus.err);
            errors++;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.in = 8'h00;
        bus.in_valid = 1'b0;
        test_reset();
        test_precedence();
        test_subtraction();
        test_wrap();
        test_errors();
        test_gaps();
        test_async_clear();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
